// File: rtl/div_pkg.sv
// Shared constants for the iterative restoring divider: default width,
// FSM encodings and iteration counter width.
package div_pkg;

    localparam int DEF_DATA_WIDTH = 32;

    // Counter must reach DATA_WIDTH itself, so it needs one bit more than log2.
    localparam int CNT_W = 6;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor magnitude from the
// already-shifted partial remainder and either keep or restore.
module div_step
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH:0]   rem_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  q_bit
);

    logic [DATA_WIDTH+1:0] diff;

    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        diff    = {1'b0, rem_in} - {2'b00, divisor};
        // Accept the difference only if it is non-negative and fits back in
        // DATA_WIDTH bits (the top bit is the borrow out of the subtraction).
        q_bit   = ~|diff[DATA_WIDTH+1:DATA_WIDTH];
        rem_out = q_bit ? diff[DATA_WIDTH-1:0] : rem_in[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider with valid/ready handshakes: one
// restoring step per cycle on magnitudes, sign fix-up on the final CALC cycle.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Quotient,
    output logic [DATA_WIDTH-1:0] Remainder,
    output logic                  DivZero
);

    localparam int W = DATA_WIDTH;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     dvd;       // dividend bits shift out, quotient bits shift in
    logic [W-1:0]     dvs;
    logic [W-1:0]     rem;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;
    logic [W-1:0]     step_rem;
    logic             step_q;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        a_neg = is_signed & A[W-1];
        b_neg = is_signed & B[W-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
    end

    div_step #(.DATA_WIDTH(W)) u_step (
        .rem_in  ({rem, dvd[W-1]}),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (B == '0) begin
                            Quotient  <= '1;
                            Remainder <= A;
                            DivZero   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            dvd   <= a_mag;
                            dvs   <= b_mag;
                            rem   <= '0;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // After DATA_WIDTH steps the extra cycle applies the signs.
                    if (cnt == CNT_W'(W)) begin
                        Quotient  <= neg_q ? -dvd : dvd;
                        Remainder <= neg_r ? -rem : rem;
                        DivZero   <= 1'b0;
                        state     <= DONE;
                    end else begin
                        rem <= step_rem;
                        dvd <= {dvd[W-2:0], step_q};
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
